// File: rtl/hv_pkg.sv
// Shared definitions for the HV watchdog register scanner.
// Holds the scan FSM state encoding and the CRC-8 constants.
package hv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_REQ   = 2'd2,
        ST_CHECK = 2'd3
    } scan_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/hv_crc8_calc.sv
// Combinational CRC-8 over a DW-bit word, MSB first.
// Polynomial and init value come from hv_pkg.
module hv_crc8_calc
    import hv_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] data,
    output logic [7:0]    crc
);

    logic [7:0] acc;
    logic       fb;

    // Bit-serial CRC unrolled across the data word
    always_comb begin
        acc = CRC8_INIT;
        fb  = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb  = acc[7] ^ data[i];
            acc = {acc[6:0], 1'b0};
            if (fb) begin
                acc = acc ^ CRC8_POLY;
            end
        end
        crc = acc;
    end

endmodule

// File: rtl/hv_wdg_reg_scan.sv
// Periodic register scanner: reads each address, checks stored CRC-8.
// Optional ack timeout enabled by macro HV_WDG_SCAN_TIMEOUT_EN.
module hv_wdg_reg_scan
    import hv_pkg::*;
#(
    parameter int REG_AW          = 7,
    parameter int REG_DW          = 8,
    parameter int REG_CRC_W       = 8,
    parameter int SCAN_ADDR_START = 'h00,
    parameter int SCAN_ADDR_END   = 'h3F,
    parameter int SCAN_PERIOD     = 1024,
    parameter int SCAN_TO         = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_scan_en,
    input  logic                 i_err_clr,
    output logic                 o_wdg_scan_rac_rd_req,
    output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
    input  logic                 i_rac_wdg_scan_ack,
    input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
    input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
    output logic                 o_scan_busy,
    output logic                 o_scan_done,
    output logic                 o_scan_crc_err,
    output logic [REG_AW-1:0]    o_scan_err_addr,
    output logic                 o_scan_to_err
);

    localparam int CNT_W = $clog2(SCAN_PERIOD + 1);
    localparam logic [REG_AW-1:0] A_START = REG_AW'(SCAN_ADDR_START);
    localparam logic [REG_AW-1:0] A_END   = REG_AW'(SCAN_ADDR_END);
    localparam logic [CNT_W-1:0]  P_LAST  = CNT_W'(SCAN_PERIOD - 1);

    scan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     per_cnt;
    logic [REG_DW-1:0]    cap_data;
    logic [REG_CRC_W-1:0] cap_crc;
    logic [7:0]           crc_calc;
    logic                 ack_ok;
    logic                 to_hit;
    logic                 advance;
    logic                 last;
    logic                 done_d;
    logic                 mismatch;

    hv_crc8_calc #(.DW(REG_DW)) u_crc (
        .data (cap_data),
        .crc  (crc_calc)
    );

    assign ack_ok   = (state_q == ST_REQ) && o_wdg_scan_rac_rd_req
                      && i_rac_wdg_scan_ack;
    assign last     = (o_wdg_scan_rac_addr == A_END);
    assign advance  = (state_q == ST_CHECK) || to_hit;
    assign mismatch = (state_q == ST_CHECK)
                      && (REG_CRC_W'(crc_calc) != cap_crc);

`ifdef HV_WDG_SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(SCAN_TO + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SCAN_TO - 1);

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state_q == ST_REQ) && o_wdg_scan_rac_rd_req
                    && !i_rac_wdg_scan_ack && (to_cnt == TO_LAST);

    // Count cycles the request has been outstanding without ack
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt        <= '0;
            o_scan_to_err <= 1'b0;
        end else begin
            if ((state_q == ST_REQ) && o_wdg_scan_rac_rd_req && !to_hit)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (to_hit)
                o_scan_to_err <= 1'b1;
            else if (i_err_clr)
                o_scan_to_err <= 1'b0;
        end
    end
`else
    assign to_hit        = 1'b0;
    assign o_scan_to_err = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic and end-of-pass detection
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_scan_en)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_scan_en)
                    state_d = ST_IDLE;
                else if (per_cnt == P_LAST)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_ok)
                    state_d = ST_CHECK;
            end
            ST_CHECK: ;
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            if (!i_scan_en)
                state_d = ST_IDLE;
            else if (last) begin
                state_d = ST_WAIT;
                done_d  = 1'b1;
            end else
                state_d = ST_REQ;
        end
    end

    // Datapath: counters, pointer, captures and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            per_cnt               <= '0;
            o_wdg_scan_rac_addr   <= '0;
            o_wdg_scan_rac_rd_req <= 1'b0;
            cap_data              <= '0;
            cap_crc               <= '0;
            o_scan_busy           <= 1'b0;
            o_scan_done           <= 1'b0;
            o_scan_crc_err        <= 1'b0;
            o_scan_err_addr       <= '0;
        end else begin
            if (state_q == ST_WAIT && state_d == ST_WAIT)
                per_cnt <= per_cnt + 1'b1;
            else
                per_cnt <= '0;

            if (state_q == ST_IDLE && i_scan_en)
                o_wdg_scan_rac_addr <= A_START;
            else if (advance)
                o_wdg_scan_rac_addr <= last ? A_START
                                       : o_wdg_scan_rac_addr + 1'b1;

            o_wdg_scan_rac_rd_req <= (state_q == ST_REQ) && !ack_ok
                                     && !to_hit;

            if (ack_ok) begin
                cap_data <= i_rac_wdg_scan_data;
                cap_crc  <= i_rac_wdg_scan_crc;
            end

            o_scan_busy <= (state_d != ST_IDLE);
            o_scan_done <= done_d;

            if (mismatch)
                o_scan_crc_err <= 1'b1;
            else if (i_err_clr)
                o_scan_crc_err <= 1'b0;

            if (mismatch && (!o_scan_crc_err || i_err_clr))
                o_scan_err_addr <= o_wdg_scan_rac_addr;
            else if (i_err_clr)
                o_scan_err_addr <= '0;
        end
    end

endmodule
